// File: rtl/pb_field_encoder.sv
// Protobuf field encoder: key varint then value varint, LSB group first.
// Wire types 0 (varint) and 2 (length prefix only) are accepted.
module pb_field_encoder #(
  parameter int FIELD_NUM_W = 29,
  parameter int VALUE_W     = 64,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FIELD_NUM_W-1:0] in_field_number,
  input  logic [2:0]             in_wire_type,
  input  logic [VALUE_W-1:0]     in_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   out_last,
  output logic                   err_pulse,
  output logic                   busy,
  output logic [CNT_W-1:0]       field_count
);

  localparam int KEY_W = FIELD_NUM_W + 3;

  typedef enum logic [1:0] {
    IDLE,
    KEY,
    VALUE
  } state_e;

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [VALUE_W-1:0] val_q, val_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic key_more;
  logic val_more;
  logic fire;
  logic good;

  assign key_more = |key_q[KEY_W-1:7];
  assign val_more = |val_q[VALUE_W-1:7];
  assign good     = ((in_wire_type == 3'd0) ||
                     (in_wire_type == 3'd2)) &&
                    (|in_field_number);

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign err_pulse   = err_q;
  assign field_count = cnt_q;
  assign fire        = out_valid && out_ready;

  always_comb begin
    out_valid = 1'b0;
    out_byte  = 8'd0;
    out_last  = 1'b0;
    unique case (state_q)
      KEY: begin
        out_valid = 1'b1;
        out_byte  = {key_more, key_q[6:0]};
      end
      VALUE: begin
        out_valid = 1'b1;
        out_byte  = {val_more, val_q[6:0]};
        out_last  = !val_more;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    val_d   = val_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (good) begin
            key_d   = {in_field_number, in_wire_type};
            val_d   = in_value;
            state_d = KEY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      KEY: begin
        if (fire) begin
          key_d = key_q >> 7;
          if (!key_more) state_d = VALUE;
        end
      end
      VALUE: begin
        if (fire) begin
          val_d = val_q >> 7;
          if (!val_more) begin
            state_d = IDLE;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      val_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      val_q   <= val_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pb_field_encoder.sv
// Bench for pb_field_encoder: directed protobuf vectors plus random
// fields checked against an arithmetic varint model.
module tb_pb_field_encoder;

  localparam int FW = 29;
  localparam int VW = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_field_number;
  logic [2:0]    in_wire_type;
  logic [VW-1:0] in_value;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_byte;
  logic          out_last;
  logic          err_pulse;
  logic          busy;
  logic [CW-1:0] field_count;

  pb_field_encoder #(
    .FIELD_NUM_W(FW),
    .VALUE_W    (VW),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_field_number(in_field_number),
    .in_wire_type   (in_wire_type),
    .in_value       (in_value),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_byte       (out_byte),
    .out_last       (out_last),
    .err_pulse      (err_pulse),
    .busy           (busy),
    .field_count    (field_count)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [7:0]    exp_q[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Reference varint: base-128 digits, low digit first, MSB = more.
  function automatic void push_varint(input logic [63:0] x);
    logic [63:0] r;
    logic [7:0]  b;
    r = x;
    do begin
      b = 8'(r % 64'd128);
      r = r / 64'd128;
      if (r != 0) b = b + 8'd128;
      exp_q.push_back(b);
    end while (r != 0);
  endfunction

  task automatic offer(input logic [FW-1:0] fn,
                       input logic [2:0] wt,
                       input logic [VW-1:0] v);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid        = 1'b1;
    in_field_number = fn;
    in_wire_type    = wt;
    in_value        = v;
    @(posedge clk);
    @(negedge clk);
    in_valid        = 1'b0;
    in_field_number = FW'($urandom);
    in_wire_type    = 3'($urandom);
    in_value        = {$urandom, $urandom};
  endtask

  // mode 0: random ready, 1: stall 3 cycles on first value byte,
  // 2: always ready. abort_at >= 0 pulses reset at that byte index.
  task automatic run_field(input logic [FW-1:0] fn,
                           input logic [2:0] wt,
                           input logic [VW-1:0] v,
                           input int mode,
                           input int abort_at);
    int   klen, idx, stall, cyc;
    logic rdy;
    idx = 0; stall = 0; cyc = 0;
    exp_q.delete();
    push_varint(64'({fn, wt}));
    klen = exp_q.size();
    push_varint(v);
    offer(fn, wt, v);
    while (idx < exp_q.size() && cyc < 100) begin
      if (abort_at == idx) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_byte", out_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", field_count, 0);
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_idle", out_valid, 0);
        return;
      end
      chk("out_valid", out_valid, 1);
      chk("out_byte", out_byte, exp_q[idx]);
      chk("out_last", out_last, 64'(idx == exp_q.size() - 1));
      chk("busy", busy, 1);
      chk("no_err", err_pulse, 0);
      if (mode == 1 && idx == klen && stall < 3) begin
        rdy = 1'b0;
        stall++;
      end else if (mode == 0) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      out_ready = rdy;
      @(posedge clk);
      if (rdy) idx++;
      if (idx == exp_q.size()) exp_cnt = exp_cnt + CW'(1);
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'($urandom_range(0, 1));
    chk("no_timeout", 64'(cyc < 100), 1);
    chk("end_valid", out_valid, 0);
    chk("end_busy", busy, 0);
    chk("field_count", field_count, exp_cnt);
  endtask

  task automatic run_bad(input logic [FW-1:0] fn,
                         input logic [2:0] wt);
    offer(fn, wt, {$urandom, $urandom});
    chk("err_pulse", err_pulse, 1);
    chk("err_no_valid", out_valid, 0);
    chk("err_idle", in_ready, 1);
    @(negedge clk);
    chk("err_once", err_pulse, 0);
    chk("err_no_valid2", out_valid, 0);
    chk("err_count", field_count, exp_cnt);
  endtask

  initial begin
    logic [FW-1:0] fn;
    logic [VW-1:0] v;
    in_valid        = 1'b0;
    in_field_number = '0;
    in_wire_type    = '0;
    in_value        = '0;
    out_ready       = 1'b0;
    #3 rst_n = 1'b0;
    #20;
    @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_byte", out_byte, 0);
    chk("reset_last", out_last, 0);
    chk("reset_err", err_pulse, 0);
    chk("reset_busy", busy, 0);
    chk("reset_count", field_count, 0);
    chk("reset_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    run_field(29'd1, 3'd0, 64'd150, 2, -1);
    run_field(29'd2, 3'd2, 64'd0, 2, -1);
    run_field(29'd16, 3'd0, 64'd1, 2, -1);
    run_field(29'd1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1);
    chk("max_len", exp_q.size(), 11);
    run_field(29'd1, 3'd0, 64'd300, 1, -1);
    run_field(29'h1FFF_FFFF, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1);
    chk("max_field_len", exp_q.size(), 15);
    run_bad(29'd1, 3'd5);
    run_bad(29'd0, 3'd0);
    run_bad(29'd7, 3'd1);

    for (int i = 0; i < 40; i++) begin
      fn = FW'($urandom) >> $urandom_range(0, FW - 1);
      if (fn == 0) fn = 1;
      v = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_field(fn, ($urandom_range(0, 1) != 0) ? 3'd2 : 3'd0,
                v, int'($urandom_range(0, 2)), -1);
      if ($urandom_range(0, 7) == 0) run_bad(fn, 3'd3);
    end

    run_field(29'd1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 3);
    run_field(29'd3, 3'd0, 64'd42, 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
